// File: rtl/rx_buf_ptr_table_if.sv
// Bus bundle for the receive-buffer pointer table: flow init, three
// independent pointer write ports and two read ports with their responses.
interface rx_buf_ptr_table_if #(
  parameter int FLOWS = 64,
  parameter int PTR_W = 16
);
  localparam int FID_W = $clog2(FLOWS);

  // new-flow initialisation
  logic             init_val;
  logic [FID_W-1:0] init_flowid;
  logic [PTR_W:0]   init_head;
  logic [PTR_W:0]   init_tail;
  logic             init_rdy;

  // per-pointer writes
  logic             head_wr_val;
  logic [FID_W-1:0] head_wr_addr;
  logic [PTR_W:0]   head_wr_data;
  logic             head_wr_rdy;
  logic             commit_wr_val;
  logic [FID_W-1:0] commit_wr_addr;
  logic [PTR_W:0]   commit_wr_data;
  logic             commit_wr_rdy;
  logic             tail_wr_val;
  logic [FID_W-1:0] tail_wr_addr;
  logic [PTR_W:0]   tail_wr_data;
  logic             tail_wr_rdy;

  // read port 0
  logic             rd0_req_val;
  logic [FID_W-1:0] rd0_req_addr;
  logic             rd0_req_rdy;
  logic             rd0_resp_val;
  logic             rd0_resp_rdy;
  logic [PTR_W:0]   rd0_resp_head;
  logic [PTR_W:0]   rd0_resp_commit;
  logic [PTR_W:0]   rd0_resp_tail;
  logic [PTR_W:0]   rd0_resp_used;
  logic [PTR_W:0]   rd0_resp_free;
  logic [PTR_W:0]   rd0_resp_avail;
  logic             rd0_resp_err;

  // read port 1
  logic             rd1_req_val;
  logic [FID_W-1:0] rd1_req_addr;
  logic             rd1_req_rdy;
  logic             rd1_resp_val;
  logic             rd1_resp_rdy;
  logic [PTR_W:0]   rd1_resp_head;
  logic [PTR_W:0]   rd1_resp_commit;
  logic [PTR_W:0]   rd1_resp_tail;
  logic [PTR_W:0]   rd1_resp_used;
  logic [PTR_W:0]   rd1_resp_free;
  logic [PTR_W:0]   rd1_resp_avail;
  logic             rd1_resp_err;

  modport master (
    output init_val, init_flowid, init_head, init_tail,
    input  init_rdy,
    output head_wr_val, head_wr_addr, head_wr_data,
    input  head_wr_rdy,
    output commit_wr_val, commit_wr_addr, commit_wr_data,
    input  commit_wr_rdy,
    output tail_wr_val, tail_wr_addr, tail_wr_data,
    input  tail_wr_rdy,
    output rd0_req_val, rd0_req_addr, rd0_resp_rdy,
    input  rd0_req_rdy, rd0_resp_val, rd0_resp_head, rd0_resp_commit, rd0_resp_tail,
    input  rd0_resp_used, rd0_resp_free, rd0_resp_avail, rd0_resp_err,
    output rd1_req_val, rd1_req_addr, rd1_resp_rdy,
    input  rd1_req_rdy, rd1_resp_val, rd1_resp_head, rd1_resp_commit, rd1_resp_tail,
    input  rd1_resp_used, rd1_resp_free, rd1_resp_avail, rd1_resp_err
  );

  modport slave (
    input  init_val, init_flowid, init_head, init_tail,
    output init_rdy,
    input  head_wr_val, head_wr_addr, head_wr_data,
    output head_wr_rdy,
    input  commit_wr_val, commit_wr_addr, commit_wr_data,
    output commit_wr_rdy,
    input  tail_wr_val, tail_wr_addr, tail_wr_data,
    output tail_wr_rdy,
    input  rd0_req_val, rd0_req_addr, rd0_resp_rdy,
    output rd0_req_rdy, rd0_resp_val, rd0_resp_head, rd0_resp_commit, rd0_resp_tail,
    output rd0_resp_used, rd0_resp_free, rd0_resp_avail, rd0_resp_err,
    input  rd1_req_val, rd1_req_addr, rd1_resp_rdy,
    output rd1_req_rdy, rd1_resp_val, rd1_resp_head, rd1_resp_commit, rd1_resp_tail,
    output rd1_resp_used, rd1_resp_free, rd1_resp_avail, rd1_resp_err
  );
endinterface

// File: rtl/rx_buf_ptr_table.sv
// Per-flow receive-buffer pointer table (head/commit/tail) with a zeroing
// sweep after reset, init/write ports and two independent 1-cycle read ports
// that return the pointers plus derived used/free/avail occupancy.
module rx_buf_ptr_table #(
  parameter int FLOWS = 64,
  parameter int PTR_W = 16
) (
  input logic clk,
  input logic rst,
  rx_buf_ptr_table_if.slave bus
);
  localparam int FID_W = $clog2(FLOWS);
  localparam logic [PTR_W:0] CAPACITY = {1'b1, {PTR_W{1'b0}}};
  localparam logic [FID_W-1:0] LAST_FLOW = FID_W'(FLOWS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_reg;
  logic [FID_W-1:0] clr_cnt_reg;
  logic             run;

  logic [PTR_W:0] head_mem   [FLOWS];
  logic [PTR_W:0] commit_mem [FLOWS];
  logic [PTR_W:0] tail_mem   [FLOWS];

  logic init_fire, head_fire, commit_fire, tail_fire;

  // Sweep state: walk every entry once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_FLOW) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign run = (state_reg == RUN);

  // Init owns the table for its cycle, so pointer writes back off while it is offered.
  assign bus.init_rdy      = run;
  assign bus.head_wr_rdy   = run & ~bus.init_val;
  assign bus.commit_wr_rdy = run & ~bus.init_val;
  assign bus.tail_wr_rdy   = run & ~bus.init_val;

  assign init_fire   = run & bus.init_val;
  assign head_fire   = bus.head_wr_val & bus.head_wr_rdy;
  assign commit_fire = bus.commit_wr_val & bus.commit_wr_rdy;
  assign tail_fire   = bus.tail_wr_val & bus.tail_wr_rdy;

  // Table update: zero sweep during CLEAR, otherwise init or independent pointer writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        head_mem[clr_cnt_reg]   <= '0;
        commit_mem[clr_cnt_reg] <= '0;
        tail_mem[clr_cnt_reg]   <= '0;
      end else if (init_fire) begin
        head_mem[bus.init_flowid]   <= bus.init_head;
        commit_mem[bus.init_flowid] <= bus.init_tail;
        tail_mem[bus.init_flowid]   <= bus.init_tail;
      end else begin
        if (head_fire)   head_mem[bus.head_wr_addr]     <= bus.head_wr_data;
        if (commit_fire) commit_mem[bus.commit_wr_addr] <= bus.commit_wr_data;
        if (tail_fire)   tail_mem[bus.tail_wr_addr]     <= bus.tail_wr_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic             req_val, req_rdy, resp_rdy, fire;
      logic [FID_W-1:0] req_addr;
      logic [PTR_W:0]   rd_head, rd_commit, rd_tail, used_next, avail_next, free_next;
      logic             err_next;

      logic           resp_val_reg;
      logic [PTR_W:0] head_reg, commit_reg, tail_reg, used_reg, free_reg, avail_reg;
      logic           err_reg;

      if (gi == 0) begin : g_p0
        assign req_val              = bus.rd0_req_val;
        assign req_addr             = bus.rd0_req_addr;
        assign resp_rdy             = bus.rd0_resp_rdy;
        assign bus.rd0_req_rdy      = req_rdy;
        assign bus.rd0_resp_val     = resp_val_reg;
        assign bus.rd0_resp_head    = head_reg;
        assign bus.rd0_resp_commit  = commit_reg;
        assign bus.rd0_resp_tail    = tail_reg;
        assign bus.rd0_resp_used    = used_reg;
        assign bus.rd0_resp_free    = free_reg;
        assign bus.rd0_resp_avail   = avail_reg;
        assign bus.rd0_resp_err     = err_reg;
      end else begin : g_p1
        assign req_val              = bus.rd1_req_val;
        assign req_addr             = bus.rd1_req_addr;
        assign resp_rdy             = bus.rd1_resp_rdy;
        assign bus.rd1_req_rdy      = req_rdy;
        assign bus.rd1_resp_val     = resp_val_reg;
        assign bus.rd1_resp_head    = head_reg;
        assign bus.rd1_resp_commit  = commit_reg;
        assign bus.rd1_resp_tail    = tail_reg;
        assign bus.rd1_resp_used    = used_reg;
        assign bus.rd1_resp_free    = free_reg;
        assign bus.rd1_resp_avail   = avail_reg;
        assign bus.rd1_resp_err     = err_reg;
      end

      // A new request may enter whenever the output slot is empty or draining.
      assign req_rdy = run & (~resp_val_reg | resp_rdy);
      assign fire    = req_val & req_rdy;

      // Occupancy is modular in PTR_W+1 bits so wrapped pointers subtract cleanly.
      assign rd_head    = head_mem[req_addr];
      assign rd_commit  = commit_mem[req_addr];
      assign rd_tail    = tail_mem[req_addr];
      assign used_next  = rd_tail - rd_head;
      assign avail_next = rd_commit - rd_head;
      assign free_next  = CAPACITY - used_next;
      assign err_next   = (used_next > CAPACITY) | (avail_next > used_next);

      // Response slot: capture pre-edge table contents on accept, hold until drained.
      always_ff @(posedge clk) begin
        if (rst) begin
          resp_val_reg <= 1'b0;
          head_reg     <= '0;
          commit_reg   <= '0;
          tail_reg     <= '0;
          used_reg     <= '0;
          free_reg     <= '0;
          avail_reg    <= '0;
          err_reg      <= 1'b0;
        end else if (fire) begin
          resp_val_reg <= 1'b1;
          head_reg     <= rd_head;
          commit_reg   <= rd_commit;
          tail_reg     <= rd_tail;
          used_reg     <= used_next;
          free_reg     <= free_next;
          avail_reg    <= avail_next;
          err_reg      <= err_next;
        end else if (resp_rdy) begin
          resp_val_reg <= 1'b0;
        end
      end
    end
  endgenerate
endmodule
